kernel_strength_sequencer: RTL and testbench
============================================

Name: kernel_strength_sequencer

Overview:
Controller that owns the kernel_choice and k_index inputs of the kernel converter. It collects user strength up/down and kernel-toggle requests and applies them only at a frame boundary, so a kernel never changes mid-frame. After each change it streams the N scaled coefficients from the converter into the convolution engine's coefficient registers over a valid/ready handshake.

Parameters:
K_RANGE, 8, number of strength steps; k_index spans 0..K_RANGE
N, 25, kernel taps (5x5), coefficient count per load
KW, $clog2(K_RANGE)+1, k_index width, matching the converter port

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at the start of each frame (vsync)
strength_up  in  1  one-cycle request: k_index +1
strength_down  in  1  one-cycle request: k_index -1
kernel_toggle  in  1  one-cycle request: invert kernel_choice
coef_in  in  32 x [0:N-1]  signed scaled kernel from the converter
kernel_choice  out  1  to converter; 0 = edge, 1 = blur
k_index  out  KW  to converter, 0..K_RANGE
coef_valid  out  1  coefficient beat valid
coef_ready  in  1  convolution engine accepts the beat
coef_addr  out  $clog2(N)  tap index of the current beat
coef_data  out  32  signed coefficient; equals coef_in[coef_addr]
busy  out  1  high in SETTLE and STREAM
kernel_updated  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset values: kernel_choice=0, k_index=0, coef_valid=0, coef_addr=0, busy=0, kernel_updated=0, state=IDLE. pend_up, pend_down and pend_tog are cleared. pend_reload=1, so the first frame after reset always loads the coefficients.
- Request latching happens in every state, every cycle:
  - strength_up sets pend_up; strength_down sets pend_down.
  - Up and down in the same cycle cancel: neither flag is set.
  - A later opposite request clears the opposite flag instead of setting its own.
  - Repeated requests of the same kind before a frame_start collapse to a single step.
  - kernel_toggle inverts pend_tog, so two toggles cancel.
- State IDLE, on frame_start:
  - Compute new_k = k_index+1 if pend_up, k_index-1 if pend_down, else unchanged. Saturate to 0..K_RANGE.
  - Compute new_c = kernel_choice ^ pend_tog.
  - Clear all pend flags, including any request that arrives in this same cycle. That request is consumed by this frame and is not carried to the next one.
  - If new_k != k_index, or new_c != kernel_choice, or pend_reload: register new_k and new_c, clear pend_reload, go to SETTLE.
  - Otherwise stay in IDLE. Saturated no-op requests and double toggles produce no stream.
- State SETTLE: lasts exactly one cycle so the combinational converter output can settle. coef_addr=0. Next state is STREAM.
- State STREAM:
  - coef_valid=1; coef_data = coef_in[coef_addr] (combinational mux).
  - k_index and kernel_choice are frozen, so coef_data stays stable while valid && !ready.
  - On valid && ready: if coef_addr == N-1, deassert coef_valid, pulse kernel_updated for one cycle, go to IDLE. Otherwise increment coef_addr.
  - With coef_ready held high the load takes N cycles. The first beat appears 2 cycles after frame_start.
- frame_start during SETTLE or STREAM is ignored. Requests received in those states stay pending until the next frame_start in IDLE.
- Reset asserted mid-stream: all state returns to reset values on the next edge, coef_valid drops immediately, and pend_reload is set so the full kernel reloads on the next frame.
- coef_addr never exceeds N-1. k_index never leaves 0..K_RANGE.

Test Plan:
- Reset, then frame_start with coef_ready=1 -> SETTLE, then 25 beats at addr 0..24 with k_index=0, choice=0; kernel_updated on the cycle after beat 24; busy high for 26 cycles.
- Three strength_up pulses, then frame_start -> k_index 0→1 (not 3); 25 beats; coef_data matches the converter at k_index=1.
- k_index=8 (K_RANGE), strength_up, frame_start -> no SETTLE, coef_valid stays 0, pend_up cleared.
- strength_up and strength_down in the same cycle, then kernel_toggle, then frame_start -> k_index unchanged, kernel_choice=1, one 25-beat load.
- During STREAM, coef_ready toggles 1,0,0,1 -> coef_addr and coef_data are held while ready=0; a strength_down issued mid-stream is applied only at the following frame_start.
- reset asserted at beat 10 -> coef_valid=0 next cycle, k_index=0; the next frame_start performs a full 25-beat reload.

Source files
------------

// File: rtl/kernel_strength_sequencer.sv
// Frame-synchronous kernel/strength controller: latches user requests, applies them at
// frame_start, then streams the converter's N coefficients over a valid/ready handshake.
module kernel_strength_sequencer #(
    parameter int K_RANGE = 8,
    parameter int N       = 25,
    parameter int KW      = $clog2(K_RANGE) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_frame_start,
    input  logic                 i_strength_up,
    input  logic                 i_strength_down,
    input  logic                 i_kernel_toggle,
    input  logic [N-1:0][31:0]   i_coef_in,
    output logic                 o_kernel_choice,
    output logic [KW-1:0]        o_k_index,
    output logic                 o_coef_valid,
    input  logic                 i_coef_ready,
    output logic [$clog2(N)-1:0] o_coef_addr,
    output logic [31:0]          o_coef_data,
    output logic                 o_busy,
    output logic                 o_kernel_updated
);
    localparam int AW = $clog2(N);
    localparam logic [KW-1:0] KMAX = KW'(K_RANGE);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_choice;
    logic [AW-1:0] r_addr;
    logic          r_kupd;
    logic          r_pend_up, r_pend_dn, r_pend_tog, r_reload;

    logic          w_up_nx, w_dn_nx, w_tog_nx;
    logic [KW-1:0] w_new_k;
    logic          w_new_c;
    logic          w_change;

    // pend_up/pend_dn form a saturating net step of -1/0/+1; they are never both set
    always_comb begin
        w_up_nx = r_pend_up;
        w_dn_nx = r_pend_dn;
        if (i_strength_up && !i_strength_down) begin
            if (r_pend_dn) w_dn_nx = 1'b0;
            else           w_up_nx = 1'b1;
        end else if (i_strength_down && !i_strength_up) begin
            if (r_pend_up) w_up_nx = 1'b0;
            else           w_dn_nx = 1'b1;
        end
        w_tog_nx = r_pend_tog ^ i_kernel_toggle;
    end

    always_comb begin
        w_new_k = r_k;
        if (r_pend_up && r_k != KMAX)       w_new_k = r_k + 1'b1;
        else if (r_pend_dn && r_k != '0)    w_new_k = r_k - 1'b1;
        w_new_c  = r_choice ^ r_pend_tog;
        w_change = (w_new_k != r_k) || (w_new_c != r_choice) || r_reload;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_choice   <= 1'b0;
            r_addr     <= '0;
            r_kupd     <= 1'b0;
            r_pend_up  <= 1'b0;
            r_pend_dn  <= 1'b0;
            r_pend_tog <= 1'b0;
            r_reload   <= 1'b1;
        end else begin
            r_kupd     <= 1'b0;
            r_pend_up  <= w_up_nx;
            r_pend_dn  <= w_dn_nx;
            r_pend_tog <= w_tog_nx;
            case (r_state)
                IDLE: begin
                    if (i_frame_start) begin
                        // requests arriving with frame_start are consumed by this frame
                        r_pend_up  <= 1'b0;
                        r_pend_dn  <= 1'b0;
                        r_pend_tog <= 1'b0;
                        if (w_change) begin
                            r_k      <= w_new_k;
                            r_choice <= w_new_c;
                            r_reload <= 1'b0;
                            r_addr   <= '0;
                            r_state  <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    r_addr  <= '0;
                    r_state <= STREAM;
                end
                STREAM: begin
                    if (i_coef_ready) begin
                        if (r_addr == LAST) begin
                            r_kupd  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_kernel_choice  = r_choice;
    assign o_k_index        = r_k;
    assign o_coef_valid     = (r_state == STREAM);
    assign o_coef_addr      = r_addr;
    assign o_coef_data      = i_coef_in[r_addr];
    assign o_busy           = (r_state != IDLE);
    assign o_kernel_updated = r_kupd;
endmodule

// File: tb/tb_kernel_strength_sequencer.sv
// Bench for kernel_strength_sequencer: scenario table, hand sequences and random traffic,
// all checked every cycle against a net-step / beat-countdown reference model.
module tb_kernel_strength_sequencer;
    localparam int K_RANGE = 8;
    localparam int N       = 25;
    localparam int KW      = $clog2(K_RANGE) + 1;
    localparam int AW      = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fs = 1'b0, up = 1'b0, dn = 1'b0, tg = 1'b0, rdy = 1'b1;
    logic [N-1:0][31:0] coef_in;
    logic              o_choice, o_valid, o_busy, o_upd;
    logic [KW-1:0]     o_k;
    logic [AW-1:0]     o_addr;
    logic [31:0]       o_data;

    always #5 clk = ~clk;

    kernel_strength_sequencer #(.K_RANGE(K_RANGE), .N(N), .KW(KW)) dut (
        .i_clk(clk), .i_reset(rst), .i_frame_start(fs),
        .i_strength_up(up), .i_strength_down(dn), .i_kernel_toggle(tg),
        .i_coef_in(coef_in), .o_kernel_choice(o_choice), .o_k_index(o_k),
        .o_coef_valid(o_valid), .i_coef_ready(rdy), .o_coef_addr(o_addr),
        .o_coef_data(o_data), .o_busy(o_busy), .o_kernel_updated(o_upd)
    );

    // converter stand-in: every (k, choice, tap) gives a distinct coefficient
    function automatic logic [31:0] conv(int k, bit c, int i);
        int v;
        v = k * 40 + i * 3 + 1;
        return c ? 32'(v) : 32'(-v);
    endfunction

    always_comb
        for (int i = 0; i < N; i++) coef_in[i] = conv(int'(o_k), o_choice, i);

    int n_chk = 0, n_fail = 0;
    int beat_cnt = 0, busy_cnt = 0, upd_cnt = 0;

    // reference model: pending step is a net value clamped to -1..1
    int m_step = 0, m_k = 0, m_mode = 0, m_addr = 0;
    bit m_tog = 0, m_reload = 1, m_c = 0, m_upd = 0;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int nk;
        bit nc, consumed, nupd;
        if (rst) begin
            m_step = 0; m_tog = 0; m_reload = 1; m_k = 0; m_c = 0;
            m_mode = 0; m_addr = 0; m_upd = 0;
            return;
        end
        consumed = 0;
        nupd = 0;
        case (m_mode)
            0: if (fs) begin
                nk = clampi(m_k + m_step, 0, K_RANGE);
                nc = m_c ^ m_tog;
                consumed = 1;
                m_step = 0; m_tog = 0;
                if (nk != m_k || nc != m_c || m_reload) begin
                    m_k = nk; m_c = nc; m_reload = 0; m_mode = 1; m_addr = 0;
                end
            end
            1: begin m_mode = 2; m_addr = 0; end
            default: if (rdy) begin
                if (m_addr == N - 1) begin m_mode = 0; nupd = 1; end
                else m_addr++;
            end
        endcase
        if (!consumed) begin
            m_step = clampi(m_step + int'(up) - int'(dn), -1, 1);
            m_tog  = m_tog ^ tg;
        end
        m_upd = nupd;
    endtask

    task automatic step(input bit fs_, up_, dn_, tg_, rdy_, rst_);
        fs = fs_; up = up_; dn = dn_; tg = tg_; rdy = rdy_; rst = rst_;
        @(negedge clk);
        chk("busy", o_busy, m_mode != 0);
        chk("valid", o_valid, m_mode == 2);
        chk("k_index", o_k, m_k);
        chk("choice", o_choice, m_c);
        chk("kupd", o_upd, m_upd);
        if (m_mode != 0) chk("addr", o_addr, m_addr);
        if (m_mode == 2) chk("data", $signed(o_data), $signed(conv(m_k, m_c, m_addr)));
        if (o_valid && rdy) beat_cnt++;
        if (o_busy) busy_cnt++;
        if (o_upd) upd_cnt++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
    endtask

    typedef struct {
        int ups; int dns; int togs; bit both;
        int exp_k; bit exp_c; bit exp_load;
    } scn_t;

    scn_t tbl[15];

    initial begin
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 1};  // down at 0 saturates, reload still forces load
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0};  // saturated no-op: no stream
        tbl[2]  = '{3, 0, 0, 0, 1, 0, 1};  // three ups collapse to one step
        tbl[3]  = '{1, 0, 0, 0, 2, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 3, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 4, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 5, 0, 1};
        tbl[7]  = '{1, 0, 0, 0, 6, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 7, 0, 1};
        tbl[9]  = '{1, 0, 0, 0, 8, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 8, 0, 0};  // up at K_RANGE saturates
        tbl[11] = '{0, 0, 1, 1, 8, 1, 1};  // up+down cancel, toggle applies
        tbl[12] = '{0, 0, 2, 0, 8, 1, 0};  // double toggle cancels
        tbl[13] = '{1, 1, 0, 0, 8, 1, 0};  // up then down cancels
        tbl[14] = '{0, 2, 1, 0, 7, 0, 1};

        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
        chk("rst_addr", o_addr, 0);
        chk("rst_valid", o_valid, 0);
        idle(2);

        for (int t = 0; t < 15; t++) begin
            if (tbl[t].both) step(0, 1, 1, 0, 1, 0);
            for (int i = 0; i < tbl[t].ups; i++)  step(0, 1, 0, 0, 1, 0);
            for (int i = 0; i < tbl[t].dns; i++)  step(0, 0, 1, 0, 1, 0);
            for (int i = 0; i < tbl[t].togs; i++) step(0, 0, 0, 1, 1, 0);
            beat_cnt = 0; busy_cnt = 0; upd_cnt = 0;
            step(1, 0, 0, 0, 1, 0);
            idle(30);
            chk($sformatf("tbl%0d_beats", t), beat_cnt, tbl[t].exp_load ? N : 0);
            chk($sformatf("tbl%0d_busy", t), busy_cnt, tbl[t].exp_load ? N + 1 : 0);
            chk($sformatf("tbl%0d_upd", t), upd_cnt, tbl[t].exp_load ? 1 : 0);
            chk($sformatf("tbl%0d_k", t), o_k, tbl[t].exp_k);
            chk($sformatf("tbl%0d_c", t), o_choice, tbl[t].exp_c);
        end

        // ready stalls 1,0,0,1; mid-stream down and frame_start wait for the next frame
        step(0, 1, 0, 0, 1, 0);
        beat_cnt = 0;
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 120 && (i < 4 || o_busy); i++) begin
            step(i == 20, 0, i == 12, 0, (i % 4 == 0) || (i % 4 == 3), 0);
        end
        chk("seqA_idle", o_busy, 0);
        chk("seqA_beats", beat_cnt, N);
        chk("seqA_k", o_k, 8);
        beat_cnt = 0;
        step(1, 0, 0, 0, 1, 0);
        idle(30);
        chk("seqA_k_after", o_k, 7);
        chk("seqA_beats2", beat_cnt, N);

        // request on the frame_start cycle is consumed, not carried over
        beat_cnt = 0;
        step(1, 1, 0, 0, 1, 0);
        idle(3);
        step(1, 0, 0, 0, 1, 0);
        idle(30);
        chk("seqB_k", o_k, 7);
        chk("seqB_beats", beat_cnt, 0);

        // reset at beat 10, then a full reload at k=0
        step(0, 1, 0, 0, 1, 0);
        beat_cnt = 0;
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 40 && beat_cnt < 10; i++) step(0, 0, 0, 0, 1, 0);
        chk("seqC_reached10", beat_cnt, 10);
        step(0, 0, 0, 0, 1, 1);
        chk("seqC_valid", o_valid, 0);
        chk("seqC_k", o_k, 0);
        beat_cnt = 0;
        step(1, 0, 0, 0, 1, 0);
        idle(30);
        chk("seqC_reload", beat_cnt, N);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
